gc_rx_decoder: RTL and testbench
================================

// Module: gc_rx_decoder
// PURPOSE
//  Receive side of the N64/GC one-wire protocol, companion to the bit-pulse transmitter.
//  Samples the bidirectional data line and measures each low pulse: <2us low = 1, >=2us low = 0.
//  Assembles bits MSB-first into bytes and detects the trailing stop bit and frame end.
//  Hands bytes to the controller-emulation logic. 48MHz sys_clk.
// PARAMETERS
//  THRESH_CYC   96   low-width cycles at/above which a bit decodes as 0 (2us)
//  MIN_LOW_CYC  12   low pulses shorter than this are glitches and ignored (0.25us)
//  MAX_LOW_CYC  240  low width that flags a stuck-low error (5us)
//  IDLE_CYC     240  high time after a bit that ends the frame (5us)
//  FILT_LEN     4    consecutive equal samples required by the optional filter
// PORTS
//  sys_clk       in   1  system clock, 48MHz
//  reset         in   1  synchronous, active-high reset
//  line_in       in   1  raw data line; asynchronous to sys_clk
//  tx_active     in   1  our transmitter is driving the line; receiver ignores it
//  rx_data       out  8  last completed byte; valid while rx_valid is high
//  rx_valid      out  1  one-cycle pulse per completed byte
//  rx_frame_done out  1  one-cycle pulse: frame ended with a correct stop bit
//  rx_err        out  1  one-cycle pulse: framing or stuck-low error
//  rx_busy       out  1  high from first falling edge until the frame ends
//  rx_byte_cnt   out  6  bytes received in the current frame; saturates at 63
// BEHAVIOUR
//  Reset values: rx_data 0, rx_valid 0, rx_frame_done 0, rx_err 0, rx_busy 0, rx_byte_cnt 0.
//  Reset state: IDLE, internal counters 0.
//  line_in passes through a 2-flop synchronizer; all edges refer to the synchronized signal (ln).
//  FSM states: IDLE, LOW, HIGH, WAIT_HI. The width counter cnt is 8 bits and resets on every state entry.
//  IDLE: on ln falling edge -> LOW; clear bit_cnt and rx_byte_cnt; rx_busy <= 1.
//  LOW: cnt++ each cycle.
//   - ln rises with cnt < MIN_LOW_CYC: glitch. Return to HIGH if in frame, or IDLE if no bit yet. Not counted.
//   - ln rises otherwise: bit = (cnt < THRESH_CYC). Shift into sreg MSB-first, bit_cnt++, -> HIGH.
//   - cnt reaches MAX_LOW_CYC: rx_err pulse; discard partial data; -> WAIT_HI.
//  HIGH: cnt++; ln falls -> LOW.
//   - cnt reaches IDLE_CYC: frame end.
//   - bit_cnt==1 and the last bit is 1: stop bit OK; rx_frame_done pulse.
//   - Otherwise: rx_err pulse.
//   - Either way -> IDLE, rx_busy <= 0. rx_byte_cnt holds until the next frame start.
//  WAIT_HI: stay until ln high, then -> IDLE with rx_busy 0.
//  Byte completion: when bit_cnt reaches 8, rx_data <= sreg and rx_valid pulses.
//   - Fires one cycle after the sync'd rising edge of the 8th bit. bit_cnt wraps to 0.
//   - rx_byte_cnt++ (saturating at 63).
//  Consequence: the stop bit leaves bit_cnt==1 at frame end.
//  tx_active high: FSM forced to IDLE next cycle. Partial data dropped, no rx_err/rx_frame_done.
//   - Edges are ignored while tx_active is high. Leaving tx_active with ln low -> WAIT_HI.
//  Simultaneous rx_valid and rx_err cannot occur (different states).
//  Reset mid-frame: everything cleared; no output pulse.
//  End-to-end latency from raw edge: 2 cycles of sync (+FILT_LEN with filter).
// CONFIGURATION
//  GC_RX_GLITCH_FILTER_EN
//   - Defined: ln changes only after FILT_LEN consecutive equal synchronized samples.
//     All widths shift equally, so decode is unaffected.
//   - Undefined: ln = synchronizer output. MIN_LOW_CYC rejection still applies.
// STRUCTURE
//  gc_pkg:
//   - FSM state enum.
//   - Timing constants: ONE_US=48, TWO_US=96, FIVE_US=240, shared with the transmitter.
//  Sub-module gc_line_sync: 2-flop synchronizer plus the optional filter.
//   - Outputs ln, ln_rise, ln_fall.
// TESTING
//  Host sends 0x00 + stop (3us-low x8, then 1us low, then idle):
//   -> rx_valid once, rx_data=0x00, rx_frame_done, rx_byte_cnt=1.
//  Host sends 0x40,0x03,0x01 + stop:
//   -> three rx_valid pulses with 0x40,0x03,0x01 in order; rx_frame_done; rx_byte_cnt=3; no rx_err.
//  5-cycle low pulse on an idle line -> no state change, rx_busy stays 0, no outputs.
//  Line held low 10us -> single rx_err at cycle ~240, no rx_valid.
//   -> After release, a following 0x00 frame decodes correctly.
//  Frame of 8 bits + 2 extra bits then idle -> rx_valid for first byte, then rx_err, no rx_frame_done.
//  tx_active asserted after 4 bits -> no outputs. Reset asserted mid-byte -> all outputs 0.
//   -> In both cases, the next frame decodes normally.

Source files
------------

// File: rtl/gc_pkg.sv
// Shared definitions for the N64/GC one-wire receiver and its companion transmitter.
// Holds the timing constants (48 MHz cycles), the receive FSM encoding and a small helper.
package gc_pkg;

    localparam int unsigned ONE_US  = 48;
    localparam int unsigned TWO_US  = 96;
    localparam int unsigned FIVE_US = 240;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_WAIT_HI
    } rx_state_e;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'h3F) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/gc_rx_decoder_if.sv
// Line-side inputs and byte-side outputs of the one-wire receiver.
// The master modport is used by the surrounding logic, the slave modport by the decoder.
interface gc_rx_decoder_if;

    logic       line_in;
    logic       tx_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_done;
    logic       rx_err;
    logic       rx_busy;
    logic [5:0] rx_byte_cnt;

    modport master (
        output line_in, tx_active,
        input  rx_data, rx_valid, rx_frame_done, rx_err, rx_busy, rx_byte_cnt
    );

    modport slave (
        input  line_in, tx_active,
        output rx_data, rx_valid, rx_frame_done, rx_err, rx_busy, rx_byte_cnt
    );

endinterface

// File: rtl/gc_line_sync.sv
// Two-flop synchronizer for the raw data line with edge detection on the synchronized level.
// Defining GC_RX_GLITCH_FILTER_EN adds a FILT_LEN-sample agreement filter after the synchronizer.
module gc_line_sync #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic line_in,
    output logic ln,
    output logic ln_rise,
    output logic ln_fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic ln_prev_q, ln_prev_d;

    // Idle line is high; reset to 1 so leaving reset never produces a false falling edge.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            ln_prev_q <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ln_prev_q <= ln_prev_d;
        end
    end

`ifdef GC_RX_GLITCH_FILTER_EN
    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    // Counts consecutive samples disagreeing with the filtered level; the FILT_LEN-th one flips it.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign ln = filt_q;
`else
    assign ln = sync2_q;
`endif

    always_comb begin
        sync1_d   = line_in;
        sync2_d   = sync1_q;
        ln_prev_d = ln;
    end

    assign ln_rise = ln & ~ln_prev_q;
    assign ln_fall = ~ln & ln_prev_q;

endmodule

// File: rtl/gc_rx_decoder.sv
// N64/GC one-wire receiver: measures low pulses, assembles MSB-first bytes, checks the stop bit.
// Optional input glitch filter is enabled with `define GC_RX_GLITCH_FILTER_EN.
module gc_rx_decoder
    import gc_pkg::*;
#(
    parameter int unsigned THRESH_CYC  = TWO_US,
    parameter int unsigned MIN_LOW_CYC = 12,
    parameter int unsigned MAX_LOW_CYC = FIVE_US,
    parameter int unsigned IDLE_CYC    = FIVE_US,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    gc_rx_decoder_if.slave        bus
);

    localparam logic [7:0] THRESH_L = 8'(THRESH_CYC);
    localparam logic [7:0] MIN_L    = 8'(MIN_LOW_CYC);
    localparam logic [7:0] MAX_L    = 8'(MAX_LOW_CYC);
    localparam logic [7:0] IDLE_L   = 8'(IDLE_CYC);

    logic ln, ln_rise, ln_fall;

    gc_line_sync #(.FILT_LEN(FILT_LEN)) u_sync (
        .sys_clk (sys_clk),
        .reset   (reset),
        .line_in (bus.line_in),
        .ln      (ln),
        .ln_rise (ln_rise),
        .ln_fall (ln_fall)
    );

    rx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    // Only the seven most recent bits are stored; the eighth joins them directly into rx_data.
    logic [6:0] sreg_q, sreg_d;
    logic       in_frame_q, in_frame_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [5:0] byte_cnt_q, byte_cnt_d;
    logic       new_bit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;
        bit_cnt_d  = bit_cnt_q;
        sreg_d     = sreg_q;
        in_frame_d = in_frame_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        byte_cnt_d = byte_cnt_q;
        new_bit    = (cnt_q < THRESH_L);

        if (bus.tx_active) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            sreg_d     = '0;
            in_frame_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (ln_fall) begin
                        state_d    = ST_LOW;
                        bit_cnt_d  = '0;
                        sreg_d     = '0;
                        byte_cnt_d = '0;
                        in_frame_d = 1'b0;
                        busy_d     = 1'b1;
                    end else if (!ln) begin
                        // Line already low with no edge seen (e.g. after tx_active): wait it out.
                        state_d = ST_WAIT_HI;
                    end
                end
                ST_LOW: begin
                    if (cnt_q >= MAX_L) begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        sreg_d    = '0;
                        cnt_d     = '0;
                        state_d   = ST_WAIT_HI;
                    end else if (ln_rise) begin
                        cnt_d = '0;
                        if (cnt_q < MIN_L) begin
                            state_d = in_frame_q ? ST_HIGH : ST_IDLE;
                            busy_d  = in_frame_q;
                        end else begin
                            state_d    = ST_HIGH;
                            in_frame_d = 1'b1;
                            sreg_d     = {sreg_q[5:0], new_bit};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_d     = {sreg_q, new_bit};
                                valid_d    = 1'b1;
                                byte_cnt_d = sat_inc6(byte_cnt_q);
                            end
                        end
                    end
                end
                ST_HIGH: begin
                    if (ln_fall) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q >= IDLE_L) begin
                        if (bit_cnt_q == 3'd1 && sreg_q[0]) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_HI: begin
                    cnt_d = '0;
                    if (ln) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            sreg_q     <= '0;
            in_frame_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sreg_q     <= sreg_d;
            in_frame_q <= in_frame_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.rx_frame_done = done_q;
    assign bus.rx_err        = err_q;
    assign bus.rx_busy       = busy_q;
    assign bus.rx_byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_gc_rx_decoder.sv
// Directed bench for gc_rx_decoder: host-style frames, glitches, stuck-low, tx_active and reset.
module tb_gc_rx_decoder;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    gc_rx_decoder_if bus ();

    gc_rx_decoder dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  got_q[$];
    int unsigned done_n  = 0;
    int unsigned err_n   = 0;
    int unsigned cyc     = 0;
    int unsigned err_cyc = 0;

    // Pulse recorder, sampled away from the active edge.
    always @(negedge sys_clk) begin
        cyc++;
        if (bus.rx_valid === 1'b1) got_q.push_back(bus.rx_data);
        if (bus.rx_frame_done === 1'b1) done_n++;
        if (bus.rx_err === 1'b1) begin
            err_n++;
            err_cyc = cyc;
        end
    end

    task automatic hold(input logic lvl, input int unsigned n);
        bus.line_in = lvl;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, b ? 48 : 144);
        hold(1'b1, b ? 144 : 48);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        hold(1'b0, 48);
        hold(1'b1, 1);
    endtask

    task automatic wait_not_busy();
        int unsigned n = 0;
        while (bus.rx_busy !== 1'b0 && n < 2000) begin
            hold(1'b1, 1);
            n++;
        end
        hold(1'b1, 4);
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_n = 0;
        err_n  = 0;
    endtask

    task automatic test_reset();
        bus.line_in   = 1'b1;
        bus.tx_active = 1'b0;
        reset = 1'b1;
        hold(1'b1, 5);
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%0h exp=0", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", bus.rx_frame_done); end
        checks++; if (bus.rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err got=%0b exp=0", bus.rx_err); end
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%0b exp=0", bus.rx_busy); end
        checks++; if (bus.rx_byte_cnt !== 6'd0) begin failures++; $display("FAIL reset_byte_cnt got=%0d exp=0", bus.rx_byte_cnt); end
        reset = 1'b0;
        hold(1'b1, 10);
        clear_obs();
    endtask

    task automatic test_zero_frame(input string tag);
        clear_obs();
        send_bit(1'b0);
        checks++; if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL %s_busy_mid got=%0b exp=1", tag, bus.rx_busy); end
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_stop();
        wait_not_busy();
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%0b exp=0", tag, bus.rx_busy); end
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL %s_valid_count got=%0d exp=1", tag, got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'h00) begin failures++; $display("FAIL %s_data got=%0h exp=00", tag, got_q[0]); end
        end
        checks++; if (done_n != 1) begin failures++; $display("FAIL %s_frame_done got=%0d exp=1", tag, done_n); end
        checks++; if (err_n != 0) begin failures++; $display("FAIL %s_err got=%0d exp=0", tag, err_n); end
        checks++; if (bus.rx_byte_cnt !== 6'd1) begin failures++; $display("FAIL %s_byte_cnt got=%0d exp=1", tag, bus.rx_byte_cnt); end
    endtask

    task automatic test_multi_byte();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h40; exp_b[1] = 8'h03; exp_b[2] = 8'h01;
        clear_obs();
        for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
        send_stop();
        wait_not_busy();
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL multi_valid_count got=%0d exp=3", got_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_q[i] !== exp_b[i]) begin failures++; $display("FAIL multi_data%0d got=%0h exp=%0h", i, got_q[i], exp_b[i]); end
            end
        end
        checks++; if (done_n != 1) begin failures++; $display("FAIL multi_frame_done got=%0d exp=1", done_n); end
        checks++; if (err_n != 0) begin failures++; $display("FAIL multi_err got=%0d exp=0", err_n); end
        checks++; if (bus.rx_byte_cnt !== 6'd3) begin failures++; $display("FAIL multi_byte_cnt got=%0d exp=3", bus.rx_byte_cnt); end
    endtask

    task automatic test_glitch();
        clear_obs();
        hold(1'b0, 5);
        hold(1'b1, 60);
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%0b exp=0", bus.rx_busy); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", got_q.size()); end
        checks++; if (done_n != 0) begin failures++; $display("FAIL glitch_done got=%0d exp=0", done_n); end
        checks++; if (err_n != 0) begin failures++; $display("FAIL glitch_err got=%0d exp=0", err_n); end
    endtask

    task automatic test_stuck_low();
        int unsigned start;
        clear_obs();
        start = cyc;
        hold(1'b0, 480);
        hold(1'b1, 60);
        checks++; if (err_n != 1) begin failures++; $display("FAIL stuck_err_count got=%0d exp=1", err_n); end
        checks++; if (err_cyc - start < 235 || err_cyc - start > 255) begin failures++; $display("FAIL stuck_err_time got=%0d exp=235..255", err_cyc - start); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL stuck_valid got=%0d exp=0", got_q.size()); end
        checks++; if (done_n != 0) begin failures++; $display("FAIL stuck_done got=%0d exp=0", done_n); end
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL stuck_busy got=%0b exp=0", bus.rx_busy); end
        test_zero_frame("after_stuck");
    endtask

    task automatic test_extra_bits();
        clear_obs();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_not_busy();
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL extra_valid_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'hA5) begin failures++; $display("FAIL extra_data got=%0h exp=a5", got_q[0]); end
        end
        checks++; if (err_n != 1) begin failures++; $display("FAIL extra_err got=%0d exp=1", err_n); end
        checks++; if (done_n != 0) begin failures++; $display("FAIL extra_done got=%0d exp=0", done_n); end
    endtask

    task automatic test_tx_active();
        clear_obs();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus.tx_active = 1'b1;
        hold(1'b1, 3);
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL tx_busy_forced got=%0b exp=0", bus.rx_busy); end
        hold(1'b0, 100);
        hold(1'b1, 100);
        bus.tx_active = 1'b0;
        hold(1'b1, 300);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL tx_valid got=%0d exp=0", got_q.size()); end
        checks++; if (err_n != 0) begin failures++; $display("FAIL tx_err got=%0d exp=0", err_n); end
        checks++; if (done_n != 0) begin failures++; $display("FAIL tx_done got=%0d exp=0", done_n); end
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL tx_busy_after got=%0b exp=0", bus.rx_busy); end
        test_zero_frame("after_tx");
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        hold(1'b1, 3);
        checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", bus.rx_busy); end
        checks++; if (bus.rx_byte_cnt !== 6'd0) begin failures++; $display("FAIL rstmid_byte_cnt got=%0d exp=0", bus.rx_byte_cnt); end
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%0h exp=0", bus.rx_data); end
        reset = 1'b0;
        hold(1'b1, 300);
        checks++; if (got_q.size() != 0 || err_n != 0 || done_n != 0) begin
            failures++; $display("FAIL rstmid_pulses got=v%0d/e%0d/d%0d exp=0/0/0", got_q.size(), err_n, done_n);
        end
        test_zero_frame("after_rst");
    endtask

    initial begin
        test_reset();
        test_zero_frame("zero");
        test_multi_byte();
        test_glitch();
        test_stuck_low();
        test_extra_bits();
        test_tx_active();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
